rv_lsu: RTL and testbench
=========================

// Module: rv_lsu
// PURPOSE
// - Load/store unit between the execute stage and the data-memory bus. Upstream of rv_writeback.
// - Takes one load/store per request from execute, checks alignment and builds byte lanes.
// - Runs the bus request/ready handshake and returns raw load words plus one-cycle done
//   strobes. Writeback does the sign/zero extension.
// PARAMETERS
// - TIMEOUT_CYCLES  255  wait cycles with no dm_ready_i before bus error; 0 = no timeout
// PORTS
// - clk_i           in   1   clock, rising edge
// - rst_n_i         in   1   reset, asynchronous, active-low
// - x_load_i        in   1   execute issues a load this cycle
// - x_store_i       in   1   execute issues a store this cycle
// - x_fun_i         in   3   access size, LDST_* funct3 encoding
// - x_dm_addr_i     in   32  byte address
// - x_store_data_i  in   32  store data, right-justified
// - dm_addr_o       out  32  bus address, word-aligned ([1:0]=0)
// - dm_data_s_o     out  32  store data, lane-replicated
// - dm_data_select_o out 4   byte enables
// - dm_load_o       out  1   bus read request, held until ready
// - dm_store_o      out  1   bus write request, held until ready
// - dm_ready_i      in   1   bus completes current request this cycle
// - dm_data_l_i     in   32  bus read data, valid when dm_ready_i=1
// - dm_data_l_o     out  32  captured load word, to writeback
// - dm_load_done_o  out  1   load complete, one-cycle pulse
// - dm_store_done_o out  1   store complete, one-cycle pulse
// - misaligned_o    out  1   access rejected for misalignment, one-cycle pulse
// - bus_error_o     out  1   access aborted on timeout, one-cycle pulse
// - busy_o          out  1   unit not idle; execute must not issue
// BEHAVIOUR
// - Reset values: all outputs 0; FSM=IDLE; timeout counter=0.
// - FSM states:
//   - IDLE: accepts x_load_i or x_store_i. If both are set, load wins and the store is dropped.
//   - LOAD_WAIT / STORE_WAIT: dm_load_o / dm_store_o and dm_addr_o, dm_data_s_o,
//     dm_data_select_o are registered on accept and held stable until dm_ready_i=1.
//   - Ready cycle: capture dm_data_l_i, go to IDLE; done pulse asserts the next cycle.
// - Accept-to-request latency is 1 cycle. Minimum request-to-done latency is 1 cycle after ready.
// - Requests seen while busy_o=1 are ignored. busy_o = (state != IDLE).
// - Lanes, with a = addr[1:0]:
//   - B/BU: select = 1<<a; data = {4{byte}}.
//   - H/HU: select = a[1] ? 1100 : 0011; data = {2{half}}.
//   - W: select = 1111; data as-is.
//   - Loads drive the same select.
// - Misalignment: H/HU with a[0]=1, or W with a!=0, starts no bus cycle. misaligned_o pulses
//   the cycle after accept and the FSM stays IDLE. Undefined funct3 values are treated as W.
// - dm_data_l_o holds its value until the next completed load; it does not clear on store.
// - Timeout: the counter increments each wait cycle with dm_ready_i=0 and clears on accept.
//   At TIMEOUT_CYCLES: drop the request, pulse bus_error_o plus the matching done strobe
//   (so writeback unstalls), return to IDLE.
// - dm_ready_i arriving in the same cycle the timeout hits counts as success, not an error.
// - dm_ready_i seen in IDLE is ignored.
// - Reset asserted mid-operation: request and strobes drop asynchronously, with no done pulse.
// STRUCTURE
// - rv_defs: LDST_B=000, LDST_H=001, LDST_L=010, LDST_BU=100, LDST_HU=101; FSM state codes.
// - Sub-module rv_lsu_align (combinational): funct3, addr[1:0], store data ->
//   select, lane data, misaligned.
// - Top level holds the FSM, the request registers, the timeout counter and the load capture.
// TESTING
// - SB addr 0x1003 data 0x000000AB, ready 1st cycle -> dm_addr_o=0x1000, select=1000,
//   data_s=0xABABABAB, store_done pulses 1 cycle after ready.
// - LW addr 0x2000, ready after 3 wait cycles with dm_data_l_i=0xDEADBEEF -> dm_load_o high
//   4 cycles, load_done one pulse, dm_data_l_o=0xDEADBEEF.
// - SH addr 0x1001 -> no dm_store_o, misaligned_o pulses once, busy_o stays 0.
// - TIMEOUT_CYCLES=4, LH with ready never asserted -> bus_error_o + load_done pulse after
//   4 wait cycles, FSM IDLE.
// - rst_n_i low during LOAD_WAIT -> dm_load_o=0 immediately, no done; next LW accepted
//   normally after release.
// - x_load_i and x_store_i together at addr 0x3002, HU -> read with select=1100, no write;
//   a request issued while busy is ignored.

Source files
------------

// File: rtl/rv_lsu_pkg.sv
// Shared encodings for the load/store unit: access-size funct3 codes and FSM states.
package rv_lsu_pkg;

    localparam logic [2:0] LDST_B  = 3'b000;
    localparam logic [2:0] LDST_H  = 3'b001;
    localparam logic [2:0] LDST_L  = 3'b010;
    localparam logic [2:0] LDST_BU = 3'b100;
    localparam logic [2:0] LDST_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_LOAD_WAIT  = 2'd1,
        ST_STORE_WAIT = 2'd2
    } lsu_state_e;

endpackage

// File: rtl/rv_lsu_align.sv
// Byte-lane builder: turns access size and low address bits into byte enables,
// lane-replicated store data and a misalignment flag.
module rv_lsu_align
    import rv_lsu_pkg::*;
(
    input  logic [2:0]  fun_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] store_data_i,
    output logic [3:0]  select_o,
    output logic [31:0] lane_data_o,
    output logic        misaligned_o
);

    always_comb begin
        // Word access; undefined size codes also fall through to here.
        select_o     = 4'b1111;
        lane_data_o  = store_data_i;
        misaligned_o = (addr_lo_i != 2'b00);
        case (fun_i)
            LDST_B, LDST_BU: begin
                select_o     = 4'b0001 << addr_lo_i;
                lane_data_o  = {4{store_data_i[7:0]}};
                misaligned_o = 1'b0;
            end
            LDST_H, LDST_HU: begin
                select_o     = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                lane_data_o  = {2{store_data_i[15:0]}};
                misaligned_o = addr_lo_i[0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/rv_lsu.sv
// Load/store unit: accepts one access from execute, runs the data-memory handshake,
// returns the raw load word and one-cycle done / error strobes.
//   state         | meaning
//   ST_IDLE       | waiting for x_load_i / x_store_i
//   ST_LOAD_WAIT  | read request on the bus, waiting for dm_ready_i
//   ST_STORE_WAIT | write request on the bus, waiting for dm_ready_i
module rv_lsu
    import rv_lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        x_load_i,
    input  logic        x_store_i,
    input  logic [2:0]  x_fun_i,
    input  logic [31:0] x_dm_addr_i,
    input  logic [31:0] x_store_data_i,
    output logic [31:0] dm_addr_o,
    output logic [31:0] dm_data_s_o,
    output logic [3:0]  dm_data_select_o,
    output logic        dm_load_o,
    output logic        dm_store_o,
    input  logic        dm_ready_i,
    input  logic [31:0] dm_data_l_i,
    output logic [31:0] dm_data_l_o,
    output logic        dm_load_done_o,
    output logic        dm_store_done_o,
    output logic        misaligned_o,
    output logic        bus_error_o,
    output logic        busy_o
);

    localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);

    lsu_state_e  state_q, state_d;
    logic [31:0] addr_q, addr_d, data_s_q, data_s_d, data_l_q, data_l_d, cnt_q, cnt_d;
    logic [3:0]  sel_q, sel_d;
    logic        load_q, load_d, store_q, store_d;
    logic        load_done_q, load_done_d, store_done_q, store_done_d;
    logic        mis_q, mis_d, err_q, err_d;

    logic [3:0]  lane_sel;
    logic [31:0] lane_data;
    logic        lane_mis;

    rv_lsu_align u_align (
        .fun_i        (x_fun_i),
        .addr_lo_i    (x_dm_addr_i[1:0]),
        .store_data_i (x_store_data_i),
        .select_o     (lane_sel),
        .lane_data_o  (lane_data),
        .misaligned_o (lane_mis)
    );

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        data_s_d     = data_s_q;
        sel_d        = sel_q;
        load_d       = load_q;
        store_d      = store_q;
        cnt_d        = cnt_q;
        data_l_d     = data_l_q;
        load_done_d  = 1'b0;
        store_done_d = 1'b0;
        mis_d        = 1'b0;
        err_d        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (x_load_i || x_store_i) begin
                    cnt_d = '0;
                    if (lane_mis) begin
                        mis_d = 1'b1;
                    end else begin
                        // Load has priority; a simultaneous store is dropped.
                        state_d  = x_load_i ? ST_LOAD_WAIT : ST_STORE_WAIT;
                        load_d   = x_load_i;
                        store_d  = !x_load_i;
                        addr_d   = {x_dm_addr_i[31:2], 2'b00};
                        data_s_d = lane_data;
                        sel_d    = lane_sel;
                    end
                end
            end
            ST_LOAD_WAIT, ST_STORE_WAIT: begin
                if (dm_ready_i || (TIMEOUT_CYCLES != 0 && cnt_q == TO_LAST)) begin
                    // Ready wins over a timeout landing on the same cycle.
                    state_d      = ST_IDLE;
                    load_d       = 1'b0;
                    store_d      = 1'b0;
                    err_d        = !dm_ready_i;
                    load_done_d  = (state_q == ST_LOAD_WAIT);
                    store_done_d = (state_q == ST_STORE_WAIT);
                    if (dm_ready_i && state_q == ST_LOAD_WAIT) begin
                        data_l_d = dm_data_l_i;
                    end
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            data_s_q     <= '0;
            sel_q        <= '0;
            load_q       <= 1'b0;
            store_q      <= 1'b0;
            cnt_q        <= '0;
            data_l_q     <= '0;
            load_done_q  <= 1'b0;
            store_done_q <= 1'b0;
            mis_q        <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            data_s_q     <= data_s_d;
            sel_q        <= sel_d;
            load_q       <= load_d;
            store_q      <= store_d;
            cnt_q        <= cnt_d;
            data_l_q     <= data_l_d;
            load_done_q  <= load_done_d;
            store_done_q <= store_done_d;
            mis_q        <= mis_d;
            err_q        <= err_d;
        end
    end

    assign dm_addr_o        = addr_q;
    assign dm_data_s_o      = data_s_q;
    assign dm_data_select_o = sel_q;
    assign dm_load_o        = load_q;
    assign dm_store_o       = store_q;
    assign dm_data_l_o      = data_l_q;
    assign dm_load_done_o   = load_done_q;
    assign dm_store_done_o  = store_done_q;
    assign misaligned_o     = mis_q;
    assign bus_error_o      = err_q;
    assign busy_o           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_rv_lsu.sv
// Self-checking bench for rv_lsu: directed scenarios plus randomized accesses
// checked against a size/offset arithmetic model of the byte lanes and handshake.
module tb_rv_lsu;

    localparam int TO = 4;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        x_load_i = 1'b0, x_store_i = 1'b0;
    logic [2:0]  x_fun_i = '0;
    logic [31:0] x_dm_addr_i = '0, x_store_data_i = '0;
    logic [31:0] dm_addr_o, dm_data_s_o, dm_data_l_o;
    logic [3:0]  dm_data_select_o;
    logic        dm_load_o, dm_store_o, dm_load_done_o, dm_store_done_o;
    logic        misaligned_o, bus_error_o, busy_o;
    logic        dm_ready_i = 1'b0;
    logic [31:0] dm_data_l_i = '0;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] last_load = '0;

    rv_lsu #(.TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .x_load_i(x_load_i), .x_store_i(x_store_i), .x_fun_i(x_fun_i),
        .x_dm_addr_i(x_dm_addr_i), .x_store_data_i(x_store_data_i),
        .dm_addr_o(dm_addr_o), .dm_data_s_o(dm_data_s_o),
        .dm_data_select_o(dm_data_select_o), .dm_load_o(dm_load_o),
        .dm_store_o(dm_store_o), .dm_ready_i(dm_ready_i), .dm_data_l_i(dm_data_l_i),
        .dm_data_l_o(dm_data_l_o), .dm_load_done_o(dm_load_done_o),
        .dm_store_done_o(dm_store_done_o), .misaligned_o(misaligned_o),
        .bus_error_o(bus_error_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    // One access end to end. delay = index of the wait cycle carrying dm_ready_i.
    task automatic do_access(input string name, input bit ld, input bit st,
                             input logic [2:0] fun, input logic [31:0] addr,
                             input logic [31:0] sdata, input int delay,
                             input logic [31:0] rdata, input bit poke);
        int          size, a;
        bit          mis, is_ld, done, err;
        logic [3:0]  esel;
        logic [31:0] edata, eaddr;
        a = int'(addr % 4);
        case (fun)
            3'b000, 3'b100: size = 1;
            3'b001, 3'b101: size = 2;
            default:        size = 4;
        endcase
        mis   = (a % size) != 0;
        esel  = 4'(((1 << size) - 1) << a);
        edata = (size == 1) ? 32'(sdata[7:0]) * 32'h01010101 :
                (size == 2) ? 32'(sdata[15:0]) * 32'h00010001 : sdata;
        eaddr = addr - 32'(a);
        is_ld = ld;

        x_load_i = ld; x_store_i = st; x_fun_i = fun;
        x_dm_addr_i = addr; x_store_data_i = sdata;
        @(posedge clk_i); #1;
        x_load_i = 1'b0; x_store_i = 1'b0;
        x_dm_addr_i = $urandom; x_store_data_i = $urandom;

        if (mis) begin
            n_checks++;
            if ({dm_load_o, dm_store_o, busy_o, misaligned_o} !== 4'b0001) begin
                n_fail++;
                $display("FAIL %s misaligned pulse: got ld/st/busy/mis=%b want 0001", name,
                         {dm_load_o, dm_store_o, busy_o, misaligned_o});
            end
            @(posedge clk_i); #1;
            n_checks++;
            if ({dm_load_o, dm_store_o, busy_o, misaligned_o} !== 4'b0000) begin
                n_fail++;
                $display("FAIL %s misaligned clear: got ld/st/busy/mis=%b want 0000", name,
                         {dm_load_o, dm_store_o, busy_o, misaligned_o});
            end
            return;
        end

        done = 1'b0; err = 1'b0;
        for (int k = 0; k < 16 && !done; k++) begin
            n_checks++;
            if ({dm_load_o, dm_store_o, busy_o, misaligned_o, bus_error_o} !== {is_ld, !is_ld, 3'b100}
                || dm_addr_o !== eaddr || dm_data_select_o !== esel
                || (!is_ld && dm_data_s_o !== edata)) begin
                n_fail++;
                $display("FAIL %s request cyc%0d: got ld=%b st=%b busy=%b addr=%h sel=%b ds=%h want ld=%b st=%b busy=1 addr=%h sel=%b ds=%h",
                         name, k, dm_load_o, dm_store_o, busy_o, dm_addr_o, dm_data_select_o,
                         dm_data_s_o, is_ld, !is_ld, eaddr, esel, edata);
            end
            if (poke && k == 0) begin
                x_load_i = 1'b1; x_store_i = 1'b1; x_dm_addr_i = 32'h0000_5000;
            end
            dm_ready_i  = (k == delay);
            dm_data_l_i = (k == delay) ? rdata : $urandom;
            if (k == delay) done = 1'b1;
            else if (k + 1 == TO) begin done = 1'b1; err = 1'b1; end
            @(posedge clk_i); #1;
            dm_ready_i = 1'b0; x_load_i = 1'b0; x_store_i = 1'b0;
        end
        if (!err && is_ld) last_load = rdata;

        n_checks++;
        if ({busy_o, dm_load_o, dm_store_o, dm_load_done_o, dm_store_done_o, bus_error_o}
                !== {3'b000, is_ld, !is_ld, err} || dm_data_l_o !== last_load) begin
            n_fail++;
            $display("FAIL %s completion: got busy/ld/st/ldone/sdone/err=%b data_l=%h want %b data_l=%h",
                     name, {busy_o, dm_load_o, dm_store_o, dm_load_done_o, dm_store_done_o, bus_error_o},
                     dm_data_l_o, {3'b000, is_ld, !is_ld, err}, last_load);
        end
        @(posedge clk_i); #1;
        n_checks++;
        if ({busy_o, dm_load_o, dm_store_o, dm_load_done_o, dm_store_done_o, bus_error_o} !== 6'b0) begin
            n_fail++;
            $display("FAIL %s strobes clear: got %b want 000000", name,
                     {busy_o, dm_load_o, dm_store_o, dm_load_done_o, dm_store_done_o, bus_error_o});
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk_i);
        #1;
        n_checks++;
        if ({dm_addr_o, dm_data_s_o, dm_data_select_o, dm_load_o, dm_store_o, dm_data_l_o,
             dm_load_done_o, dm_store_done_o, misaligned_o, bus_error_o, busy_o} !== '0) begin
            n_fail++;
            $display("FAIL reset outputs: got addr=%h ds=%h sel=%b ld=%b st=%b dl=%h busy=%b want all 0",
                     dm_addr_o, dm_data_s_o, dm_data_select_o, dm_load_o, dm_store_o, dm_data_l_o, busy_o);
        end
        rst_n_i = 1'b1;
        @(posedge clk_i); #1;
    endtask

    task automatic test_idle_ready();
        dm_ready_i = 1'b1; dm_data_l_i = 32'h1234_5678;
        repeat (3) @(posedge clk_i);
        #1;
        dm_ready_i = 1'b0;
        n_checks++;
        if ({busy_o, dm_load_done_o, dm_store_done_o, bus_error_o} !== 4'b0 || dm_data_l_o !== last_load) begin
            n_fail++;
            $display("FAIL idle_ready: got busy/ldone/sdone/err=%b dl=%h want 0000 dl=%h",
                     {busy_o, dm_load_done_o, dm_store_done_o, bus_error_o}, dm_data_l_o, last_load);
        end
    endtask

    task automatic test_reset_mid();
        x_load_i = 1'b1; x_fun_i = 3'b010; x_dm_addr_i = 32'h0000_0040;
        @(posedge clk_i); #1;
        x_load_i = 1'b0;
        @(posedge clk_i); #1;
        n_checks++;
        if (dm_load_o !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid pre: got dm_load_o=%b want 1", dm_load_o);
        end
        #2 rst_n_i = 1'b0;
        #1;
        n_checks++;
        if ({dm_load_o, busy_o, dm_load_done_o, bus_error_o, dm_data_l_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid async: got ld=%b busy=%b ldone=%b err=%b dl=%h want all 0",
                     dm_load_o, busy_o, dm_load_done_o, bus_error_o, dm_data_l_o);
        end
        last_load = '0;
        @(posedge clk_i); #1;
        rst_n_i = 1'b1;
        repeat (2) begin
            @(posedge clk_i); #1;
            n_checks++;
            if ({dm_load_o, busy_o, dm_load_done_o, dm_store_done_o, bus_error_o} !== 5'b0) begin
                n_fail++;
                $display("FAIL reset_mid after: got ld/busy/ldone/sdone/err=%b want 00000",
                         {dm_load_o, busy_o, dm_load_done_o, dm_store_done_o, bus_error_o});
            end
        end
        do_access("reset_mid_lw", 1, 0, 3'b010, 32'h0000_0080, 32'h0, 1, 32'hCAFE_F00D, 0);
    endtask

    task automatic test_random();
        int op;
        for (int i = 0; i < 60; i++) begin
            op = int'($urandom_range(0, 2));
            do_access("random", op != 1, op != 0, 3'($urandom_range(0, 7)), $urandom,
                      $urandom, int'($urandom_range(0, 5)), $urandom, $urandom_range(0, 3) == 0);
        end
    endtask

    initial begin
        test_reset();
        do_access("sb_1003", 0, 1, 3'b000, 32'h0000_1003, 32'h0000_00AB, 0, 32'h0, 0);
        do_access("lw_2000", 1, 0, 3'b010, 32'h0000_2000, 32'h0, 3, 32'hDEAD_BEEF, 0);
        do_access("sw_keeps_load", 0, 1, 3'b010, 32'h0000_2004, 32'h1111_2222, 1, 32'h0, 0);
        do_access("sh_1001_mis", 0, 1, 3'b001, 32'h0000_1001, 32'h0000_BEEF, 0, 32'h0, 0);
        do_access("lw_2002_mis", 1, 0, 3'b010, 32'h0000_2002, 32'h0, 0, 32'h0, 0);
        do_access("lh_timeout", 1, 0, 3'b001, 32'h0000_0010, 32'h0, 100, 32'h0, 0);
        do_access("sb_timeout", 0, 1, 3'b000, 32'h0000_0011, 32'h55, 100, 32'h0, 0);
        do_access("hu_both_3002", 1, 1, 3'b101, 32'h0000_3002, 32'h0000_7777, 2, 32'hA5A5_0F0F, 1);
        test_idle_ready();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
